// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
// Control sequencer for the shared 32-bit multiply/divide datapath of the execute
// stage. A one-cycle ctrl_MULT/ctrl_DIV request latches the operands and the
// operation. The selected unit then receives a single-cycle start. The sequencer
// waits for the unit's ready and returns the captured result with a one-cycle
// data_resultRDY. busy stays high meanwhile so that the pipeline stalls.
//
// During the first MIN_WAIT wait cycles the unit's ready is ignored, because a unit
// that has been idle may still be showing the ready of its previous operation.
// A unit that never answers is cut off after TIMEOUT wait cycles. The operation
// then completes with result 0 and the exception flag set.
module multdiv_sequencer #(
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 48
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] mult_A,
   output logic [31:0] mult_B,
   output logic        mult_start,
   input  logic [31:0] mult_result,
   input  logic        mult_ready,
   input  logic        mult_overflow,
   output logic [31:0] div_A,
   output logic [31:0] div_B,
   output logic        div_start,
   input  logic [31:0] div_result,
   input  logic        div_ready,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // The wait counter is 6 bits wide, so TIMEOUT must stay below 64.
   localparam logic [5:0] MIN_WAIT_C   = 6'(MIN_WAIT);
   localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
   localparam logic [5:0] CNT_MAX      = 6'h3F;
   localparam logic       OP_MUL       = 1'b0;
   localparam logic       OP_DIV       = 1'b1;

   state_t      state_q, state_d;
   logic        op_q, op_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [5:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] result_q, result_d;
   logic        exception_q, exception_d;
   logic        mult_start_q, mult_start_d;
   logic        div_start_q, div_start_d;
   logic        result_rdy_q, result_rdy_d;
   logic        busy_q, busy_d;

   logic        req_any;
   logic        req_div;
   logic        unit_ready;
   logic [31:0] unit_result;
   logic        unit_exception;
   logic        ready_honoured;
   logic        timed_out;

   // Request decode: when both pulses arrive together, the multiply wins.
   always_comb begin
      req_any = ctrl_MULT | ctrl_DIV;
      req_div = ctrl_DIV & ~ctrl_MULT;
   end

   // Select the active unit's handshake by the latched operation, and qualify its ready.
   always_comb begin
      unit_ready     = (op_q == OP_DIV) ? div_ready  : mult_ready;
      unit_result    = (op_q == OP_DIV) ? div_result : mult_result;
      unit_exception = (op_q == OP_DIV) ? 1'b0       : mult_overflow;
      ready_honoured = unit_ready && (wait_cnt_q >= MIN_WAIT_C);
      // The counter reaches TIMEOUT on this cycle's increment.
      timed_out      = (wait_cnt_q >= TIMEOUT_LAST);
   end

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      wait_cnt_d   = wait_cnt_q;
      result_d     = result_q;
      exception_d  = exception_q;
      mult_start_d = 1'b0;
      div_start_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (req_any) begin
               op_d    = req_div ? OP_DIV : OP_MUL;
               opa_d   = data_operandA;
               opb_d   = data_operandB;
               state_d = ST_LAUNCH;
               // The start pulse is registered here so that it coincides with LAUNCH.
               // A zero divisor never starts the divider.
               mult_start_d = ~req_div;
               div_start_d  = req_div & (data_operandB != 32'd0);
            end
         end

         ST_LAUNCH: begin
            wait_cnt_d = 6'd0;
            if ((op_q == OP_DIV) && (opb_q == 32'd0)) begin
               // Divide by zero: the divider was not started, so complete immediately.
               result_d    = 32'd0;
               exception_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 6'd1;
            end
            // A ready takes priority over a timeout that expires in the same cycle.
            if (ready_honoured) begin
               result_d    = unit_result;
               exception_d = unit_exception;
               state_d     = ST_DONE;
            end else if (timed_out) begin
               result_d    = 32'd0;
               exception_d = 1'b1;
               state_d     = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // busy and data_resultRDY are registered views of the state being entered.
      busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
      result_rdy_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset aborts any operation in flight and clears everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_MUL;
         opa_q        <= 32'd0;
         opb_q        <= 32'd0;
         wait_cnt_q   <= 6'd0;
         result_q     <= 32'd0;
         exception_q  <= 1'b0;
         mult_start_q <= 1'b0;
         div_start_q  <= 1'b0;
         result_rdy_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         wait_cnt_q   <= wait_cnt_d;
         result_q     <= result_d;
         exception_q  <= exception_d;
         mult_start_q <= mult_start_d;
         div_start_q  <= div_start_d;
         result_rdy_q <= result_rdy_d;
         busy_q       <= busy_d;
      end
   end

   // One latched operand pair feeds both units and is held from accept to the next accept.
   assign mult_A         = opa_q;
   assign mult_B         = opb_q;
   assign div_A          = opa_q;
   assign div_B          = opb_q;
   assign mult_start     = mult_start_q;
   assign div_start      = div_start_q;
   assign data_result    = result_q;
   assign data_exception = exception_q;
   assign data_resultRDY = result_rdy_q;
   assign busy           = busy_q;

endmodule
